// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encodings and
// the digit-counter width helper.
package cmp_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_t;

    // Counter width for n digits; a single-digit compare still needs one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit unsigned magnitude comparator; the generalised
// form of the original 2-bit comparator.
module cmp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] da,
    input  logic [DIGIT-1:0] db,
    output logic             dgt,
    output logic             dlt
);

    assign dgt = (da > db);
    assign dlt = (da < db);

endmodule

// File: rtl/comparator_nbit_serial.sv
// MSB-first digit-serial magnitude comparator with start/busy/done handshake.
// Define CMP_EARLY_EXIT_EN to finish at the first differing digit; otherwise constant NDIG-cycle latency.
module comparator_nbit_serial
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q;
    logic             mode_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, gt_q, eq_q, lt_q;

    logic [DIGIT-1:0] da, db;
    logic             dgt, dlt;

    // Flipping the sign bit maps two's complement onto offset binary, so the
    // plain unsigned digit compare orders signed operands correctly.
    always_comb begin
        da = sa_q[WIDTH-1 -: DIGIT];
        db = sb_q[WIDTH-1 -: DIGIT];
        if (mode_q && (cnt_q == '0)) begin
            da[DIGIT-1] = ~da[DIGIT-1];
            db[DIGIT-1] = ~db[DIGIT-1];
        end
    end

    cmp_digit #(.DIGIT(DIGIT)) u_digit (
        .da  (da),
        .db  (db),
        .dgt (dgt),
        .dlt (dlt)
    );

`ifndef CMP_EARLY_EXIT_EN
    logic sgt_q, slt_q;
    logic gt_d, lt_d;

    // Once a difference has been latched, later digits no longer matter.
    assign gt_d = (sgt_q | slt_q) ? sgt_q : dgt;
    assign lt_d = (sgt_q | slt_q) ? slt_q : dlt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
            sgt_q   <= 1'b0;
            slt_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        mode_q  <= signed_mode;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CMP;
`ifndef CMP_EARLY_EXIT_EN
                        sgt_q   <= 1'b0;
                        slt_q   <= 1'b0;
`endif
                    end
                end
                ST_CMP: begin
`ifdef CMP_EARLY_EXIT_EN
                    if (dgt || dlt) begin
                        gt_q    <= dgt;
                        lt_q    <= dlt;
                        eq_q    <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == LAST) begin
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        eq_q    <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        sa_q  <= sa_q << DIGIT;
                        sb_q  <= sb_q << DIGIT;
                        cnt_q <= cnt_q + CW'(1);
                    end
`else
                    if (cnt_q == LAST) begin
                        gt_q    <= gt_d;
                        lt_q    <= lt_d;
                        eq_q    <= ~(gt_d | lt_d);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        if (!(sgt_q || slt_q)) begin
                            sgt_q <= dgt;
                            slt_q <= dlt;
                        end
                        sa_q  <= sa_q << DIGIT;
                        sb_q  <= sb_q << DIGIT;
                        cnt_q <= cnt_q + CW'(1);
                    end
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;

endmodule
